uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; SHALL be a power of two, 2 to 256.
REQ-002 Port i_Clock  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-003 Port i_Reset  input  1  reset, synchronous and active-high.
REQ-004 Port i_Wr_En  input  1  write strobe; one byte per cycle while high.
REQ-005 Port i_Wr_Byte  input  8  byte to queue.
REQ-006 Port o_Full  output  1  high when count equals DEPTH.
REQ-007 Port o_Empty  output  1  high when count equals 0.
REQ-008 Port o_Count  output  log2(DEPTH)+1  bytes currently stored.
REQ-009 Port o_Overflow  output  1  one-cycle pulse when a write is dropped.
REQ-010 Port o_Tx_DV  output  1  to transmitter i_Tx_DV; one-cycle start pulse.
REQ-011 Port o_Tx_Byte  output  8  to transmitter i_Tx_Byte; held stable from the o_Tx_DV cycle until i_Tx_Done.
REQ-012 Port i_Tx_Done  input  1  from transmitter o_Tx_Done; one-cycle pulse at end of stop bit.

Function
REQ-013 Storage SHALL be a DEPTH x 8 circular buffer with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 A write SHALL be accepted on an edge where i_Wr_En=1 and o_Full=0 (value before the edge); i_Wr_Byte is stored at the write pointer, which increments.
REQ-015 Write with o_Full=1 SHALL be dropped, even if a pop occurs on the same edge; pointers and data SHALL be unchanged; o_Overflow SHALL be 1 for the following cycle only.
REQ-016 o_Count, o_Full and o_Empty SHALL be registered and updated on the same edge as the accepted write or pop; a simultaneous write and pop SHALL leave o_Count unchanged.
REQ-017 Control FSM states: IDLE, SEND, WAIT_DONE.
REQ-018 IDLE: if o_Empty=0, on the next edge pop the head byte into o_Tx_Byte, increment the read pointer, and go to SEND; else stay.
REQ-019 SEND: o_Tx_DV=1 for exactly this one cycle; unconditionally go to WAIT_DONE.
REQ-020 WAIT_DONE: o_Tx_DV=0; on the edge where i_Tx_Done=1, go to IDLE; else stay indefinitely.
REQ-021 i_Tx_Done in IDLE or SEND SHALL be ignored.
REQ-022 Latency: write accepted at edge N into an empty FIFO with FSM in IDLE -> o_Empty=0 after edge N, pop at edge N+1, o_Tx_DV=1 in cycle after edge N+1.
REQ-023 Back-to-back: i_Tx_Done sampled at edge M with FIFO non-empty -> IDLE after M, pop at M+1, o_Tx_DV=1 after M+1 (two-cycle gap between Done and next DV).
REQ-024 Bytes SHALL be transmitted in write order with no loss, duplication or reordering, including across pointer wrap.
REQ-025 o_Tx_Byte SHALL change only on a pop edge.

Reset
REQ-026 While i_Reset=1 at an edge: pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, FSM=IDLE.
REQ-027 Reset SHALL take priority over writes, pops and i_Tx_Done on the same edge.
REQ-028 Reset mid-transfer (SEND or WAIT_DONE) SHALL discard all queued bytes and return to IDLE; a later stray i_Tx_Done SHALL be ignored.
REQ-029 Buffer RAM contents need not be cleared by reset.

Verification
REQ-030 Reset, single write 8'h3F -> o_Count 0->1->0, one o_Tx_DV pulse with o_Tx_Byte=8'h3F two edges after the write; no second pulse until i_Tx_Done.
REQ-031 Write 8'h01..8'h08 on consecutive cycles with transmitter model returning i_Tx_Done 870 cycles after each DV -> o_Full=1 reached if no pop yet, bytes delivered in order 01..08, one DV per Done.
REQ-032 Fill to DEPTH while WAIT_DONE, then write 8'hAA -> o_Overflow pulses 1 cycle, o_Count stays 8, 8'hAA never transmitted.
REQ-033 Stream 20 bytes (0x10..0x23) in bursts to force pointer wrap -> all 20 transmitted in order, o_Empty=1 at end.
REQ-034 Simultaneous write and pop at o_Count=3 -> o_Count remains 3; write while full coincident with pop -> dropped, o_Overflow=1.
REQ-035 Assert i_Reset during WAIT_DONE with 5 bytes queued, then pulse i_Tx_Done -> o_Count=0, o_Empty=1, no o_Tx_DV after reset.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-queue interface between a producer, the TX FIFO and a UART transmitter.
//   master : producer/transmitter side, drives i_Wr_En, i_Wr_Byte, i_Tx_Done
//   slave  : FIFO side, drives status and the transmitter start strobe/byte
interface uart_tx_fifo_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          i_Wr_En;
   logic [7:0]    i_Wr_Byte;
   logic          o_Full;
   logic          o_Empty;
   logic [CW-1:0] o_Count;
   logic          o_Overflow;
   logic          o_Tx_DV;
   logic [7:0]    o_Tx_Byte;
   logic          i_Tx_Done;

   modport master (
      output i_Wr_En, i_Wr_Byte, i_Tx_Done,
      input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
   );

   modport slave (
      input  i_Wr_En, i_Wr_Byte, i_Tx_Done,
      output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues bytes from a producer and hands
// them one at a time to the transmitter, waiting for its done pulse between bytes.
//   i_Clock : single rising-edge clock
//   i_Reset : synchronous active-high reset, highest priority
//   bus     : slave modport of uart_tx_fifo_if (write side, status, TX handshake)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no byte in flight; pops the head byte when FIFO non-empty
// SEND      | o_Tx_DV high for this single cycle
// WAIT_DONE | byte handed off; waits for i_Tx_Done from the transmitter
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input logic           i_Clock,
   input logic           i_Reset,
   uart_tx_fifo_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [7:0]    tx_byte;
   logic          tx_dv;
   logic          pop;
   logic          wr_acc;

   // Full is the registered value before the edge, so a write into a full
   // FIFO is dropped even when a pop frees a slot on the same edge.
   assign wr_acc = bus.i_Wr_En & ~full;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (!empty) state_nxt = ST_SEND;
         ST_SEND:      state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (bus.i_Tx_Done) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pop   = 1'b0;
      tx_dv = 1'b0;
      case (state)
         ST_IDLE: pop   = ~empty;
         ST_SEND: tx_dv = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      count_nxt = count;
      case ({wr_acc, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         tx_byte  <= 8'h00;
      end else begin
         overflow <= bus.i_Wr_En & full;
         count    <= count_nxt;
         full     <= (count_nxt == FULL_CNT);
         empty    <= (count_nxt == '0);
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            tx_byte <= mem[rd_ptr];
         end
      end
   end

   // Storage is not cleared by reset; pointers alone define validity.
   always_ff @(posedge i_Clock) begin
      if (wr_acc && !i_Reset) mem[wr_ptr] <= bus.i_Wr_Byte;
   end

   assign bus.o_Full     = full;
   assign bus.o_Empty    = empty;
   assign bus.o_Count    = count;
   assign bus.o_Overflow = overflow;
   assign bus.o_Tx_DV    = tx_dv;
   assign bus.o_Tx_Byte  = tx_byte;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_uart_tx_fifo;
   localparam int DEPTH = 8;

   logic i_Clock = 1'b0;
   logic i_Reset;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .bus     (bus)
   );

   always #5 i_Clock = ~i_Clock;

   // reference model: byte queue plus transfer phase (0 idle, 1 start, 2 waiting)
   logic [7:0] q[$];
   int         phase;
   logic [7:0] m_byte;
   logic       m_ovf;

   // transmitter model
   bit tx_armed;
   int tx_cnt;
   int lat_min;
   int lat_max;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rst, input logic wr, input logic [7:0] b,
                             input logic done);
      bit acc;
      if (rst) begin
         q.delete();
         phase  = 0;
         m_byte = 8'h00;
         m_ovf  = 1'b0;
         return;
      end
      m_ovf = wr && (q.size() == DEPTH);
      acc   = wr && (q.size() < DEPTH);
      case (phase)
         0: if (q.size() > 0) begin
               m_byte = q.pop_front();
               phase  = 1;
            end
         1: phase = 2;
         default: if (done) phase = 0;
      endcase
      if (acc) q.push_back(b);
   endtask

   task automatic tick(input logic rst, input logic wr, input logic [7:0] b,
                       input logic extra_done);
      logic done;
      done = extra_done;
      if (tx_armed) begin
         if (tx_cnt <= 1) begin
            done     = 1'b1;
            tx_armed = 1'b0;
         end else begin
            tx_cnt--;
         end
      end
      i_Reset       = rst;
      bus.i_Wr_En   = wr;
      bus.i_Wr_Byte = b;
      bus.i_Tx_Done = done;
      @(posedge i_Clock);
      model_edge(rst, wr, b, done);
      if (rst) tx_armed = 1'b0;
      @(negedge i_Clock);
      chk("count",    32'(bus.o_Count),    32'(q.size()));
      chk("full",     32'(bus.o_Full),     32'(q.size() == DEPTH));
      chk("empty",    32'(bus.o_Empty),    32'(q.size() == 0));
      chk("overflow", 32'(bus.o_Overflow), 32'(m_ovf));
      chk("tx_dv",    32'(bus.o_Tx_DV),    32'(phase == 1));
      chk("tx_byte",  32'(bus.o_Tx_Byte),  32'(m_byte));
      if (phase == 1) begin
         tx_armed = 1'b1;
         tx_cnt   = $urandom_range(lat_max, lat_min);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() > 0 || phase != 0) && n < 20000) begin
         tick(1'b0, 1'b0, 8'h00, 1'b0);
         n++;
      end
      chk("drain_timeout", 32'(n < 20000), 32'd1);
   endtask

   initial begin
      int n;
      int wr_pct;
      phase    = 0;
      m_byte   = 8'h00;
      m_ovf    = 1'b0;
      tx_armed = 1'b0;
      tx_cnt   = 0;
      lat_min  = 2;
      lat_max  = 2;

      // reset state
      repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0);

      // single byte, no second start until done
      lat_min = 40; lat_max = 40;
      tick(1'b0, 1'b1, 8'h3F, 1'b0);
      repeat (60) tick(1'b0, 1'b0, 8'h00, 1'b0);

      // eight bytes with a slow transmitter
      lat_min = 870; lat_max = 870;
      for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, i[7:0], 1'b0);
      drain();

      // fill while waiting, then overflow with 8'hAA
      lat_min = 100; lat_max = 100;
      tick(1'b0, 1'b1, 8'h50, 1'b0);
      repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, 8'h50 + i[7:0], 1'b0);
      tick(1'b0, 1'b1, 8'hAA, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      drain();

      // 20 bytes in bursts across pointer wrap
      lat_min = 3; lat_max = 6;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'h10 + 8'(k * 5 + i), 1'b0);
         repeat (10) tick(1'b0, 1'b0, 8'h00, 1'b0);
      end
      drain();

      // simultaneous write and pop at count 3, then at full
      lat_min = 10; lat_max = 10;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'hC0 + i[7:0], 1'b0);
      n = 0;
      while (phase != 0 && n < 100) begin tick(1'b0, 1'b0, 8'h00, 1'b0); n++; end
      tick(1'b0, 1'b1, 8'hC4, 1'b0);
      n = 0;
      while (q.size() < DEPTH && n < 100) begin tick(1'b0, 1'b1, 8'hD0 + n[7:0], 1'b0); n++; end
      n = 0;
      while (phase != 0 && n < 100) begin tick(1'b0, 1'b1, 8'hEE, 1'b0); n++; end
      tick(1'b0, 1'b1, 8'hEF, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      drain();

      // reset during a transfer with five bytes queued, then a stray done
      lat_min = 200; lat_max = 200;
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'h60 + i[7:0], 1'b0);
      repeat (5) tick(1'b0, 1'b0, 8'h00, 1'b0);
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (20) tick(1'b0, 1'b0, 8'h00, 1'b0);

      // randomized traffic
      lat_min = 2; lat_max = 15;
      wr_pct  = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) wr_pct = $urandom_range(90, 20);
         tick(($urandom % 400) == 0,
              ($urandom % 100) < wr_pct,
              8'($urandom),
              ($urandom % 50) == 0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
